// File: rtl/pbkdf2_iter_driver_pkg.sv
// Package pbkdf2_pkg: shared constants and types for the PBKDF2-HMAC-SHA256 driver.
//   IPAD / OPAD  : 64-byte HMAC pad patterns, XORed with the padded key.
//   PAD_TAIL     : SHA-256 padding for a 96-byte message (64B key block + 32B U).
//                  It is the 0x80 marker, zero fill and a 64-bit length of 768 bits.
//   drv_state_e  : driver FSM states.
package pbkdf2_pkg;

    localparam logic [511:0] IPAD     = {64{8'h36}};
    localparam logic [511:0] OPAD     = {64{8'h5c}};
    localparam logic [255:0] PAD_TAIL = {8'h80, 184'h0, 64'h300};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISEND = 3'd1,
        ST_IWAIT = 3'd2,
        ST_OSEND = 3'd3,
        ST_OWAIT = 3'd4,
        ST_DONE  = 3'd5
    } drv_state_e;

endpackage

// File: rtl/pbkdf2_iter_driver_if.sv
// Interface pbkdf2_iter_driver_if: bundles the three handshakes of the driver.
//   job side    : key_i, u1_i, iters_i, job_valid_i / job_ready_o
//   hasher side : msg_o, msg_valid_o / msg_ready_i ; dig_i, dig_valid_i / dig_ready_o
//   result side : dk_o, dk_valid_o / dk_ready_i
// Signal suffixes are named from the driver's point of view.
// The slave modport is used by the driver, and the master modport by its environment.
interface pbkdf2_iter_driver_if #(
    parameter int ITER_W = 32
);
    logic [511:0]      key_i;
    logic [255:0]      u1_i;
    logic [ITER_W-1:0] iters_i;
    logic              job_valid_i;
    logic              job_ready_o;
    logic [1023:0]     msg_o;
    logic              msg_valid_o;
    logic              msg_ready_i;
    logic [255:0]      dig_i;
    logic              dig_valid_i;
    logic              dig_ready_o;
    logic [255:0]      dk_o;
    logic              dk_valid_o;
    logic              dk_ready_i;

    modport slave (
        input  key_i, u1_i, iters_i, job_valid_i, msg_ready_i,
               dig_i, dig_valid_i, dk_ready_i,
        output job_ready_o, msg_o, msg_valid_o, dig_ready_o, dk_o, dk_valid_o
    );

    modport master (
        output key_i, u1_i, iters_i, job_valid_i, msg_ready_i,
               dig_i, dig_valid_i, dk_ready_i,
        input  job_ready_o, msg_o, msg_valid_o, dig_ready_o, dk_o, dk_valid_o
    );
endinterface

// File: rtl/pbkdf2_hmac_fmt.sv
// pbkdf2_hmac_fmt: combinational builder for one single-block-pair HMAC hash message.
//   i_key     [511:0]  padded key
//   i_pad_sel          0 = inner (IPAD), 1 = outer (OPAD)
//   i_u       [255:0]  32-byte payload (U or inner digest)
//   o_msg    [1023:0]  {key^pad, payload, SHA-256 padding}
// The U1 generator uses the same block.
module pbkdf2_hmac_fmt
    import pbkdf2_pkg::*;
(
    input  logic [511:0]  i_key,
    input  logic          i_pad_sel,
    input  logic [255:0]  i_u,
    output logic [1023:0] o_msg
);

    logic [511:0] w_pad;

    assign w_pad = i_pad_sel ? OPAD : IPAD;
    assign o_msg = {i_key ^ w_pad, i_u, PAD_TAIL};

endmodule

// File: rtl/pbkdf2_iter_driver.sv
// pbkdf2_iter_driver: runs the PBKDF2-HMAC-SHA256 U-chain for one derived-key block.
//   The driver issues an inner and an outer hash job per iteration to a sha256_1024in hasher.
//   It XOR-accumulates every U into T.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   bus (slave)      : job / hasher / result handshakes, see pbkdf2_iter_driver_if
//   perf_cycles_o    : only when PBKDF2_DRV_PERF_EN is defined. It is a saturating count of
//                      non-IDLE cycles in the current or last job, and it is cleared on job accept.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | job_ready_o=1, waiting for a job
// ST_ISEND | present inner message {K^ipad, U, pad}
// ST_IWAIT | accept inner digest into u_reg
// ST_OSEND | present outer message {K^opad, inner, pad}
// ST_OWAIT | accept outer digest: U, T ^= U, rem -= 1
// ST_DONE  | present T on dk_o until consumed
module pbkdf2_iter_driver
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pbkdf2_iter_driver_if.slave  bus
`ifdef PBKDF2_DRV_PERF_EN
    ,
    output logic [31:0]          perf_cycles_o
`endif
);

    drv_state_e        r_state;
    logic [511:0]      r_key;
    logic [255:0]      r_u;
    logic [255:0]      r_t;
    logic [ITER_W-1:0] r_rem;
    logic              r_job_ready;
    logic [1023:0]     r_msg;
    logic              r_msg_valid;
    logic              r_dig_ready;
    logic [255:0]      r_dk;
    logic              r_dk_valid;

    logic              w_pad_sel;
    logic [1023:0]     w_msg;
    logic              w_accept;

    assign w_pad_sel = (r_state == ST_OSEND);
    assign w_accept  = (r_state == ST_IDLE) && r_job_ready && bus.job_valid_i;

    pbkdf2_hmac_fmt u_fmt (
        .i_key     (r_key),
        .i_pad_sel (w_pad_sel),
        .i_u       (r_u),
        .o_msg     (w_msg)
    );

    // Each SEND/WAIT/DONE state spends its first cycle raising its registered
    // output and then waits for the handshake. Outputs therefore never depend
    // combinationally on the partner's signals.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_u         <= '0;
            r_t         <= '0;
            r_rem       <= '0;
            r_job_ready <= 1'b1;
            r_msg       <= '0;
            r_msg_valid <= 1'b0;
            r_dig_ready <= 1'b0;
            r_dk        <= '0;
            r_dk_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_job_ready <= 1'b0;
                        r_key       <= bus.key_i;
                        r_u         <= bus.u1_i;
                        r_t         <= bus.u1_i;
                        // A count of 0 behaves like 1: U1 alone is the result.
                        r_rem       <= (bus.iters_i == '0) ? '0 : bus.iters_i - ITER_W'(1);
                        r_state     <= (bus.iters_i <= ITER_W'(1)) ? ST_DONE : ST_ISEND;
                    end
                end
                ST_ISEND, ST_OSEND: begin
                    if (!r_msg_valid) begin
                        r_msg       <= w_msg;
                        r_msg_valid <= 1'b1;
                    end else if (bus.msg_ready_i) begin
                        r_msg_valid <= 1'b0;
                        r_state     <= (r_state == ST_ISEND) ? ST_IWAIT : ST_OWAIT;
                    end
                end
                ST_IWAIT: begin
                    if (!r_dig_ready) begin
                        r_dig_ready <= 1'b1;
                    end else if (bus.dig_valid_i) begin
                        r_dig_ready <= 1'b0;
                        r_u         <= bus.dig_i;
                        r_state     <= ST_OSEND;
                    end
                end
                ST_OWAIT: begin
                    if (!r_dig_ready) begin
                        r_dig_ready <= 1'b1;
                    end else if (bus.dig_valid_i) begin
                        r_dig_ready <= 1'b0;
                        r_u         <= bus.dig_i;
                        r_t         <= r_t ^ bus.dig_i;
                        r_rem       <= r_rem - ITER_W'(1);
                        r_state     <= (r_rem == ITER_W'(1)) ? ST_DONE : ST_ISEND;
                    end
                end
                ST_DONE: begin
                    if (!r_dk_valid) begin
                        r_dk_valid <= 1'b1;
                        r_dk       <= r_t;
                    end else if (bus.dk_ready_i) begin
                        r_dk_valid  <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.job_ready_o = r_job_ready;
    assign bus.msg_o       = r_msg;
    assign bus.msg_valid_o = r_msg_valid;
    assign bus.dig_ready_o = r_dig_ready;
    assign bus.dk_o        = r_dk;
    assign bus.dk_valid_o  = r_dk_valid;

`ifdef PBKDF2_DRV_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if ((r_state != ST_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf;
`endif

endmodule
